mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Memory-access controller that sits directly upstream of the LC-3 word memory.
//  Holds MAR and MDR and runs the MIO.EN / R.W / R handshake with the control FSM.
//  Drives the memory's en/ctrl/addr/in with wait states and captures read data into MDR.
//  Flags accesses beyond the populated address range.
// PARAMETERS
//  ADDR_SIZE    16  MAR / memory address width
//  DATA_SIZE    16  MDR / bus / memory data width
//  WAIT_CYCLES  2   cycles mem_en is held per access; legal range 1..15
//  ADDR_LIMIT   17  number of populated words; legal addresses are 0..ADDR_LIMIT-1
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous reset, active-high
//  bus_in     in   DATA_SIZE  shared datapath bus
//  ld_mar     in   1          load MAR from bus_in[ADDR_SIZE-1:0]
//  ld_mdr     in   1          load MDR from bus_in
//  mio_en     in   1          access request from the control FSM
//  r_w        in   1          0 = read, 1 = write; sampled with mio_en
//  ready      out  1          R: access complete, one-cycle pulse
//  err        out  1          out-of-range access; pulses together with ready
//  mar_out    out  ADDR_SIZE  current MAR
//  mdr_out    out  DATA_SIZE  current MDR, gated onto the bus by GateMDR
//  mem_en     out  1          to memory en
//  mem_ctrl   out  1          to memory ctrl (0 read, 1 write)
//  mem_addr   out  ADDR_SIZE  to memory addr
//  mem_wdata  out  DATA_SIZE  to memory in
//  mem_rdata  in   DATA_SIZE  from memory out
// BEHAVIOUR
//  Reset: all registers and outputs go to 0 immediately (async); state = IDLE.
//    Applies mid-access: mem_en drops at once, MDR is not updated, no ready pulse.
//  Output timing: every output is registered; none depends combinationally on an input.
//  Memory port wiring: mem_addr = MAR, mem_wdata = MDR, always.
//  States:
//   IDLE
//    - ld_mar / ld_mdr take effect at the next edge. Both may assert together.
//    - mio_en=1 samples r_w into the op register and compares MAR against ADDR_LIMIT.
//    - In range: next state ACCESS; wait counter loads WAIT_CYCLES-1; mem_en=1;
//      mem_ctrl=op.
//    - Out of range: next state ACCESS with mem_en held at 0 and the err flag latched.
//   ACCESS
//    - Runs for exactly WAIT_CYCLES cycles; the counter decrements each cycle.
//    - ld_mar and ld_mdr are ignored; MAR, MDR and op are frozen.
//    - On the cycle where the counter reads 0:
//        in-range read: MDR <= mem_rdata.
//        out-of-range read: MDR <= 0.
//        any write: MDR is unchanged.
//      mem_en and mem_ctrl go to 0 at that edge; next state DONE.
//   DONE
//    - ready=1 (and err=1 if flagged) for this single cycle; next state IDLE unconditionally.
//    - ld_mar / ld_mdr are honoured in DONE.
//  Latency: mio_en sampled high at edge N gives mem_en high for cycles N+1..N+W
//    (W = WAIT_CYCLES) and ready high in cycle N+W+1.
//  Back-to-back accesses:
//    - If mio_en is still high in the IDLE cycle after DONE, a new access starts.
//    - The control FSM must drop mio_en in the cycle after it sees ready.
//    - Minimum spacing between accesses is W+2 cycles.
//  Read data into MDR is captured only by the controller; ld_mdr always loads from bus_in.
//  mem_ctrl never changes while mem_en=1. Writes are therefore glitch-free at the
//    level-sensitive memory.
// TESTING
//  1. Write then read: MAR=0x0005, MDR=0xBEEF, write, then read. ready at N+3 both times;
//     memory word 5 = 0xBEEF; MDR=0xBEEF after the read.
//  2. Out of range: MAR=0x0020, read. mem_en stays 0; ready and err pulse at N+3; MDR=0x0000.
//  3. Reset mid-access: assert rst in the 2nd ACCESS cycle of a read of word 5.
//     mem_en=0 immediately; MAR=MDR=0; ready never pulses.
//  4. Loads during access: ld_mar=1 with bus=0x0003 during ACCESS. MAR unchanged and the
//     access uses the original address. The same load issued in DONE updates MAR to 0x0003.
//  5. Held mio_en: mio_en held high across DONE. A second access starts; ready pulses are
//     exactly W+2 cycles apart.
//  6. Single wait state: WAIT_CYCLES=1. Read of word 0 gives mem_en high for exactly
//     1 cycle and ready at N+2.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_if
//  Description : Bus bundle between the control FSM/datapath, the memory
//                access controller and the word memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_ctrl_if #(
    parameter int ADDR_SIZE = 16,
    parameter int DATA_SIZE = 16
) ();
    logic [DATA_SIZE-1:0] bus_in;
    logic                 ld_mar;
    logic                 ld_mdr;
    logic                 mio_en;
    logic                 r_w;
    logic                 ready;
    logic                 err;
    logic [ADDR_SIZE-1:0] mar_out;
    logic [DATA_SIZE-1:0] mdr_out;
    logic                 mem_en;
    logic                 mem_ctrl;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [DATA_SIZE-1:0] mem_rdata;

    // Controller side.
    modport slave (
        input  bus_in, ld_mar, ld_mdr, mio_en, r_w, mem_rdata,
        output ready, err, mar_out, mdr_out, mem_en, mem_ctrl, mem_addr, mem_wdata
    );

    // Control FSM / memory side.
    modport master (
        output bus_in, ld_mar, ld_mdr, mio_en, r_w, mem_rdata,
        input  ready, err, mar_out, mdr_out, mem_en, mem_ctrl, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : MAR/MDR holder and MIO.EN/R.W/R handshake engine in front of
//                the LC-3 word memory, with wait states and range checking.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int ADDR_SIZE   = 16,
    parameter int DATA_SIZE   = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_LIMIT  = 17
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_access_ctrl_if.slave   ctl
);

    localparam logic [3:0]         c_wait_load  = 4'(WAIT_CYCLES - 1);
    localparam logic [ADDR_SIZE:0] c_addr_limit = (ADDR_SIZE + 1)'(ADDR_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] mar_q, mar_d;
    logic [DATA_SIZE-1:0] mdr_q, mdr_d;
    logic                 op_q, op_d;
    logic                 oor_q, oor_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_ctrl_q, mem_ctrl_d;
    logic                 ready_q, ready_d;
    logic                 err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mar_q      <= '0;
            mdr_q      <= '0;
            op_q       <= 1'b0;
            oor_q      <= 1'b0;
            cnt_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_ctrl_q <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            op_q       <= op_d;
            oor_q      <= oor_d;
            cnt_q      <= cnt_d;
            mem_en_q   <= mem_en_d;
            mem_ctrl_q <= mem_ctrl_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mar_d      = mar_q;
        mdr_d      = mdr_q;
        op_d       = op_q;
        oor_d      = oor_q;
        cnt_d      = cnt_q;
        mem_en_d   = mem_en_q;
        mem_ctrl_d = mem_ctrl_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctl.ld_mar) mar_d = ctl.bus_in[ADDR_SIZE-1:0];
                if (ctl.ld_mdr) mdr_d = ctl.bus_in;
                if (ctl.mio_en) begin
                    // Check the address the access will actually drive, so a
                    // same-cycle MAR load is range-checked consistently.
                    op_d       = ctl.r_w;
                    oor_d      = ({1'b0, mar_d} >= c_addr_limit);
                    cnt_d      = c_wait_load;
                    mem_en_d   = ~oor_d;
                    mem_ctrl_d = ctl.r_w & ~oor_d;
                    state_d    = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!op_q) mdr_d = oor_q ? '0 : ctl.mem_rdata;
                    mem_en_d   = 1'b0;
                    mem_ctrl_d = 1'b0;
                    ready_d    = 1'b1;
                    err_d      = oor_q;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_DONE: begin
                if (ctl.ld_mar) mar_d = ctl.bus_in[ADDR_SIZE-1:0];
                if (ctl.ld_mdr) mdr_d = ctl.bus_in;
                oor_d   = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ctl.ready     = ready_q;
    assign ctl.err       = err_q;
    assign ctl.mar_out   = mar_q;
    assign ctl.mdr_out   = mdr_q;
    assign ctl.mem_en    = mem_en_q;
    assign ctl.mem_ctrl  = mem_ctrl_q;
    assign ctl.mem_addr  = mar_q;
    assign ctl.mem_wdata = mdr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Directed bench for mem_access_ctrl (W=2 and W=1 instances)
//                with a ready/err/MDR scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int W_A = 2;
    localparam int W_B = 1;

    typedef struct {
        int          cyc;
        logic        err;
        logic [15:0] mdr;
    } exp_t;

    logic clk;
    logic rst;
    logic mem_init;
    int   cyc;
    int   total;
    int   bad;
    int   ra_last;
    int   ra_prev;
    exp_t qa[$];
    exp_t qb[$];
    logic [15:0] mem_a [0:31];

    mem_access_ctrl_if #(.ADDR_SIZE(16), .DATA_SIZE(16)) ia ();
    mem_access_ctrl_if #(.ADDR_SIZE(16), .DATA_SIZE(16)) ib ();

    mem_access_ctrl #(.ADDR_SIZE(16), .DATA_SIZE(16), .WAIT_CYCLES(W_A), .ADDR_LIMIT(17))
        u_dut_a (.clk(clk), .rst(rst), .ctl(ia));

    mem_access_ctrl #(.ADDR_SIZE(16), .DATA_SIZE(16), .WAIT_CYCLES(W_B), .ADDR_LIMIT(17))
        u_dut_b (.clk(clk), .rst(rst), .ctl(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level-sensitive word memory behind instance A.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem_a[i] <= 16'h1000 + 16'(i);
        end else if (ia.mem_en && ia.mem_ctrl) begin
            mem_a[ia.mem_addr[4:0]] <= ia.mem_wdata;
        end
    end
    assign ia.mem_rdata = mem_a[ia.mem_addr[4:0]];
    assign ib.mem_rdata = 16'h1000 + ib.mem_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (ia.ready) begin
            ra_prev = ra_last;
            ra_last = cyc;
            if (qa.size() == 0) chk("a_unexpected_ready", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_ready_cycle", cyc, e.cyc);
                chk("a_err", ia.err, e.err);
                chk("a_mdr", ia.mdr_out, e.mdr);
            end
        end else begin
            chk("a_err_without_ready", ia.err, 0);
            if (qa.size() > 0 && qa[0].cyc < cyc) begin
                e = qa.pop_front();
                chk("a_ready_missing", 0, 1);
            end
        end
        if (ib.ready) begin
            if (qb.size() == 0) chk("b_unexpected_ready", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_ready_cycle", cyc, e.cyc);
                chk("b_err", ib.err, e.err);
                chk("b_mdr", ib.mdr_out, e.mdr);
            end
        end else if (qb.size() > 0 && qb[0].cyc < cyc) begin
            e = qb.pop_front();
            chk("b_ready_missing", 0, 1);
        end
    endtask

    task automatic load_a(input logic mar, input logic [15:0] val);
        ia.bus_in = val;
        ia.ld_mar = mar;
        ia.ld_mdr = ~mar;
        tick();
        ia.ld_mar = 1'b0;
        ia.ld_mdr = 1'b0;
    endtask

    // One full access on instance A (W_A = 2), ending back in IDLE.
    task automatic acc_a(input logic op, input logic exp_err, input logic [15:0] exp_mdr,
                         input logic exp_en);
        int n;
        ia.mio_en = 1'b1;
        ia.r_w    = op;
        tick();
        n = cyc;
        ia.mio_en = 1'b0;
        ia.r_w    = 1'b0;
        qa.push_back('{n + W_A, exp_err, exp_mdr});
        chk("a_mem_en_c1", ia.mem_en, exp_en);
        chk("a_mem_ctrl_c1", ia.mem_ctrl, exp_en & op);
        tick();
        chk("a_mem_en_c2", ia.mem_en, exp_en);
        chk("a_mem_ctrl_c2", ia.mem_ctrl, exp_en & op);
        tick();
        chk("a_mem_en_done", ia.mem_en, 0);
        tick();
    endtask

    initial begin
        int n;
        total = 0; bad = 0; cyc = 0; ra_last = 0; ra_prev = 0;
        rst = 1'b1; mem_init = 1'b1;
        ia.bus_in = '0; ia.ld_mar = 0; ia.ld_mdr = 0; ia.mio_en = 0; ia.r_w = 0;
        ib.bus_in = '0; ib.ld_mar = 0; ib.ld_mdr = 0; ib.mio_en = 0; ib.r_w = 0;
        tick(); tick();
        chk("rst_mar", ia.mar_out, 0);
        chk("rst_mdr", ia.mdr_out, 0);
        chk("rst_mem_en", ia.mem_en, 0);
        chk("rst_ready", ia.ready, 0);
        rst = 1'b0; mem_init = 1'b0;
        tick();

        // Write then read word 5.
        load_a(1'b1, 16'h0005);
        chk("mar_load", ia.mar_out, 16'h0005);
        chk("mem_addr", ia.mem_addr, 16'h0005);
        load_a(1'b0, 16'hBEEF);
        chk("mdr_load", ia.mdr_out, 16'hBEEF);
        chk("mem_wdata", ia.mem_wdata, 16'hBEEF);
        acc_a(1'b1, 1'b0, 16'hBEEF, 1'b1);
        chk("mem_word5", mem_a[5], 16'hBEEF);
        load_a(1'b0, 16'h1234);
        acc_a(1'b0, 1'b0, 16'hBEEF, 1'b1);
        chk("read_mdr", ia.mdr_out, 16'hBEEF);

        // Range edges: last legal word, first illegal, and 0x0020.
        load_a(1'b1, 16'd16);
        acc_a(1'b0, 1'b0, 16'h1010, 1'b1);
        load_a(1'b1, 16'd17);
        acc_a(1'b0, 1'b1, 16'h0000, 1'b0);
        load_a(1'b1, 16'h0020);
        load_a(1'b0, 16'h7777);
        acc_a(1'b0, 1'b1, 16'h0000, 1'b0);
        chk("oor_mdr", ia.mdr_out, 16'h0000);
        load_a(1'b0, 16'h5A5A);
        acc_a(1'b1, 1'b1, 16'h5A5A, 1'b0);
        chk("oor_write_mem0", mem_a[0], 16'h1000);

        // Reset in the second ACCESS cycle of a read of word 5.
        load_a(1'b1, 16'h0005);
        load_a(1'b0, 16'h5555);
        ia.mio_en = 1'b1; ia.r_w = 1'b0;
        tick();
        ia.mio_en = 1'b0;
        chk("pre_rst_mem_en", ia.mem_en, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("async_rst_mem_en", ia.mem_en, 0);
        chk("async_rst_mar", ia.mar_out, 0);
        chk("async_rst_mdr", ia.mdr_out, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("post_rst_mdr", ia.mdr_out, 0);

        // MAR load ignored in ACCESS, honoured in DONE.
        load_a(1'b1, 16'h0005);
        ia.mio_en = 1'b1; ia.r_w = 1'b0;
        tick();
        n = cyc;
        ia.mio_en = 1'b0;
        qa.push_back('{n + W_A, 1'b0, 16'hBEEF});
        ia.bus_in = 16'h0003; ia.ld_mar = 1'b1;
        tick();
        chk("access_mar_frozen", ia.mar_out, 16'h0005);
        chk("access_addr_frozen", ia.mem_addr, 16'h0005);
        tick();
        chk("last_access_mar_frozen", ia.mar_out, 16'h0005);
        tick();
        ia.ld_mar = 1'b0;
        chk("done_mar_load", ia.mar_out, 16'h0003);
        tick();

        // mio_en held across DONE: back-to-back reads of word 3.
        ia.mio_en = 1'b1; ia.r_w = 1'b0;
        tick();
        n = cyc;
        qa.push_back('{n + W_A, 1'b0, 16'h1003});
        qa.push_back('{n + 2 * W_A + 2, 1'b0, 16'h1003});
        while (cyc < n + W_A + 2) tick();
        chk("b2b_mem_en_2nd", ia.mem_en, 1);
        while (cyc < n + 2 * W_A + 2) tick();
        ia.mio_en = 1'b0;
        chk("b2b_spacing", ra_last - ra_prev, W_A + 2);
        tick(); tick();
        chk("b2b_no_third", ia.mem_en, 0);

        // Single wait state instance: read word 0.
        ib.bus_in = 16'h0000; ib.ld_mar = 1'b1;
        tick();
        ib.ld_mar = 1'b0;
        ib.mio_en = 1'b1; ib.r_w = 1'b0;
        tick();
        n = cyc;
        ib.mio_en = 1'b0;
        qb.push_back('{n + W_B, 1'b0, 16'h1000});
        chk("w1_mem_en_on", ib.mem_en, 1);
        tick();
        chk("w1_mem_en_off", ib.mem_en, 0);
        tick(); tick();
        chk("w1_mdr", ib.mdr_out, 16'h1000);

        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
